// File: rtl/waveform_capture.sv
// Circular-buffer waveform capture: pre-trigger fill, armed dwell, post-trigger record,
// and indexed readback of the completed record relative to the trigger sample.
module waveform_capture #(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned RECORD_LEN = 1000,
    parameter int unsigned PRE_TRIG   = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] adc_in,
    input  logic        trigger,
    input  logic        arm,
    input  logic [15:0] rd_addr,
    input  logic        rd_en,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic [15:0] wave_number
);
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW       = $clog2(RECORD_LEN + 1);
    localparam int unsigned POST_LEN = RECORD_LEN - PRE_TRIG - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ARMED,
        S_POST,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   start_ptr_q, start_ptr_d;
    logic [CW-1:0]   fill_cnt_q, fill_cnt_d;
    logic [CW-1:0]   post_cnt_q, post_cnt_d;
    logic            trig_prev_q, trig_prev_d;
    logic [15:0]     wave_q, wave_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            rd_valid_q, rd_valid_d;
    logic [15:0]     rd_data_q;

    logic            wr_en_c;
    logic            trig_edge_c;
    logic            rd_ok_c;
    logic            rd_in_range_c;
    logic [AW-1:0]   rd_ptr_c;

    logic [13:0]     mem [DEPTH];

    // Next-state, pointer and counter logic
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        start_ptr_d = start_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        post_cnt_d  = post_cnt_q;
        wave_d      = wave_q;
        trig_prev_d = trigger;
        wr_en_c     = 1'b0;
        trig_edge_c = trigger & ~trig_prev_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d    = S_FILL;
                    fill_cnt_d = '0;
                end
            end
            S_FILL: begin
                wr_en_c    = 1'b1;
                fill_cnt_d = fill_cnt_q + CW'(1);
                if (fill_cnt_q == CW'(PRE_TRIG - 1)) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                wr_en_c = 1'b1;
                if (trig_edge_c) begin
                    // The sample written this cycle becomes record index PRE_TRIG
                    start_ptr_d = wr_ptr_q - AW'(PRE_TRIG);
                    post_cnt_d  = '0;
                    if (POST_LEN == 0) begin
                        state_d = S_DONE;
                        wave_d  = wave_q + 16'd1;
                    end else begin
                        state_d = S_POST;
                    end
                end
            end
            S_POST: begin
                wr_en_c    = 1'b1;
                post_cnt_d = post_cnt_q + CW'(1);
                if (post_cnt_q == CW'(POST_LEN - 1)) begin
                    state_d = S_DONE;
                    wave_d  = wave_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        busy_d = (state_d == S_FILL) || (state_d == S_ARMED) || (state_d == S_POST);
        done_d = (state_d == S_DONE);

        rd_ok_c       = (state_q == S_DONE) && rd_en;
        rd_in_range_c = 32'(rd_addr) < RECORD_LEN;
        rd_valid_d    = rd_ok_c;
        rd_ptr_c      = start_ptr_q + AW'(rd_addr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            start_ptr_q <= '0;
            fill_cnt_q  <= '0;
            post_cnt_q  <= '0;
            trig_prev_q <= 1'b0;
            wave_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            start_ptr_q <= start_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            post_cnt_q  <= post_cnt_d;
            trig_prev_q <= trig_prev_d;
            wave_q      <= wave_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Sample storage: write port only, contents never reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr_q] <= adc_in;
        end
    end

    // Registered read port; output register clears on reset or an invalid read
    always_ff @(posedge clk) begin
        if (rst || !(rd_ok_c && rd_in_range_c)) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= {2'b00, mem[rd_ptr_c]};
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign wave_number = wave_q;

endmodule

// File: tb/tb_waveform_capture.sv
// Bench for waveform_capture: timestamp-based capture model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_waveform_capture;
    localparam int unsigned DEPTH      = 1024;
    localparam int unsigned RECORD_LEN = 1000;
    localparam int unsigned PRE_TRIG   = 100;
    localparam int unsigned POST_LEN   = RECORD_LEN - PRE_TRIG - 1;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic [13:0] adc_in  = '0;
    logic        trigger = 1'b0;
    logic        arm     = 1'b0;
    logic [15:0] rd_addr = '0;
    logic        rd_en   = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic [15:0] wave_number;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    waveform_capture #(
        .DEPTH     (DEPTH),
        .RECORD_LEN(RECORD_LEN),
        .PRE_TRIG  (PRE_TRIG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .adc_in     (adc_in),
        .trigger    (trigger),
        .arm        (arm),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .done       (done),
        .wave_number(wave_number)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the capture by timestamps: the record is the PRE_TRIG samples before the
    // accepted trigger edge, the edge sample, and the samples that follow it.
    localparam int M_IDLE = 0, M_FILL = 1, M_ARMED = 2, M_POST = 3, M_DONE = 4;
    logic [13:0] hist [0:65535];
    int          m_cyc      = 0;
    int          m_mode     = M_IDLE;
    int          arm_cyc    = 0;
    int          edge_cyc   = 0;
    int          rec_base   = 0;
    logic        m_prev_trg = 1'b0;
    logic [15:0] m_wave     = '0;
    logic        m_rd_valid = 1'b0;
    logic [15:0] m_rd_data  = '0;
    logic        m_busy     = 1'b0;
    logic        m_done     = 1'b0;
    logic        chk_en     = 1'b0;

    always @(posedge clk) begin
        hist[16'(m_cyc)] = adc_in;
        if (rst) begin
            chk_en     = 1'b1;
            m_mode     = M_IDLE;
            m_wave     = '0;
            m_rd_valid = 1'b0;
            m_rd_data  = '0;
            m_prev_trg = 1'b0;
        end else begin
            m_rd_valid = (m_mode == M_DONE) && rd_en;
            m_rd_data  = '0;
            if (m_rd_valid && (32'(rd_addr) < RECORD_LEN))
                m_rd_data = {2'b00, hist[16'(rec_base + int'(rd_addr))]};
            case (m_mode)
                M_IDLE, M_DONE: if (arm) begin
                    m_mode  = M_FILL;
                    arm_cyc = m_cyc;
                end
                M_FILL: if (m_cyc == arm_cyc + int'(PRE_TRIG)) m_mode = M_ARMED;
                M_ARMED: if (trigger && !m_prev_trg) begin
                    edge_cyc = m_cyc;
                    m_mode   = M_POST;
                end
                M_POST: if (m_cyc == edge_cyc + int'(POST_LEN)) begin
                    m_mode   = M_DONE;
                    m_wave   = m_wave + 16'd1;
                    rec_base = edge_cyc - int'(PRE_TRIG);
                end
                default: m_mode = M_IDLE;
            endcase
            m_prev_trg = trigger;
        end
        m_busy = (m_mode == M_FILL) || (m_mode == M_ARMED) || (m_mode == M_POST);
        m_done = (m_mode == M_DONE);
        m_cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("wave_number", 32'(wave_number), 32'(m_wave));
            check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
            check("rd_data", 32'(rd_data), 32'(m_rd_data));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        adc_in = 14'(cyc);
    endtask

    task automatic do_read(input logic [15:0] a, output logic [15:0] d, output logic v);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        d     = rd_data;
        v     = rd_valid;
        rd_en = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        check("done_reached", 32'(done), 32'd1);
        check("post_latency", 32'(n), 32'(POST_LEN));
    endtask

    // Arm is taken on the edge after this call; FILL then runs for PRE_TRIG edges
    task automatic arm_and_fill();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (PRE_TRIG) tick();
    endtask

    // Dwell in ARMED for 'dwell' edges, then present a rising trigger edge
    task automatic trigger_and_finish(input int dwell, output logic [13:0] ev);
        repeat (dwell) tick();
        trigger = 1'b1;
        ev      = adc_in;
        tick();
        wait_done();
        trigger = 1'b0;
    endtask

    task automatic read_record(input logic [13:0] ev);
        logic [15:0] d, prev;
        logic        v;
        prev = '0;
        for (int i = 0; i < int'(RECORD_LEN); i++) begin
            do_read(16'(i), d, v);
            if (i == 0) check("rec_idx0", 32'(d), 32'({2'b00, 14'(ev - 14'd100)}));
            else        check("rec_contig", 32'(d), 32'({2'b00, 14'(prev[13:0] + 14'd1)}));
            if (i == int'(PRE_TRIG)) check("rec_idx100", 32'(d), 32'({2'b00, ev}));
            prev = d;
        end
    endtask

    initial begin
        logic [13:0] ev1, ev2, ev3;
        logic [15:0] d;
        logic        v;

        // Reset and idle behaviour
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wave", 32'(wave_number), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        repeat (5) tick();
        check("idle_hold", 32'(busy), 0);

        // Ramp capture: trigger 500 edges into ARMED
        arm_and_fill();
        check("armed_busy", 32'(busy), 1);
        trigger_and_finish(500, ev1);
        check("ramp_wave", 32'(wave_number), 1);
        read_record(ev1);

        // Read bounds
        do_read(16'd999, d, v);
        check("rd999_valid", 32'(v), 1);
        check("rd999_data", 32'(d), 32'({2'b00, 14'(ev1 + 14'd899)}));
        do_read(16'd1000, d, v);
        check("rd1000_valid", 32'(v), 1);
        check("rd1000_data", 32'(d), 0);
        do_read(16'hFFFF, d, v);
        check("rdffff_valid", 32'(v), 1);
        check("rdffff_data", 32'(d), 0);
        rd_addr = 16'd5;
        tick();
        check("rden0_valid", 32'(rd_valid), 0);
        check("rden0_data", 32'(rd_data), 0);

        // Early trigger: rises in FILL, still high entering ARMED, re-rises 20 edges in
        arm = 1'b1;
        tick();
        arm = 1'b0;
        repeat (10) tick();
        trigger = 1'b1;
        repeat (PRE_TRIG - 10) tick();
        repeat (5) tick();
        check("early_no_capture", 32'(busy), 1);
        trigger = 1'b0;
        trigger_and_finish(15, ev2);
        check("early_wave", 32'(wave_number), 2);
        do_read(16'd100, d, v);
        check("early_idx100", 32'(d), 32'({2'b00, ev2}));

        // Reset 50 edges into POST abandons the capture
        arm_and_fill();
        repeat (30) tick();
        trigger = 1'b1;
        tick();
        repeat (50) tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        trigger = 1'b0;
        check("rpost_busy", 32'(busy), 0);
        check("rpost_done", 32'(done), 0);
        check("rpost_wave", 32'(wave_number), 0);
        repeat (10) tick();
        check("rpost_idle", 32'(busy), 0);

        // Arm while ARMED is ignored; capture completes normally
        arm_and_fill();
        repeat (10) tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_in_armed_busy", 32'(busy), 1);
        trigger_and_finish(20, ev1);
        check("arm_ignored_wave", 32'(wave_number), 1);

        // Back-to-back from reset; first capture puts the record start at 1000 (wraps)
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        arm_and_fill();
        trigger_and_finish(1000, ev1);
        check("b2b_wave1", 32'(wave_number), 1);
        read_record(ev1);

        // Arm together with a DONE read: old record returned, FILL entered
        rd_en = 1'b1; rd_addr = 16'd5; arm = 1'b1;
        tick();
        rd_en = 1'b0; arm = 1'b0;
        check("b2b_old_valid", 32'(rd_valid), 1);
        check("b2b_old_data", 32'(rd_data), 32'({2'b00, 14'(ev1 - 14'd95)}));
        check("b2b_fill_busy", 32'(busy), 1);
        repeat (PRE_TRIG) tick();
        trigger_and_finish(40, ev2);
        check("b2b_wave2", 32'(wave_number), 2);

        rd_en = 1'b1; rd_addr = 16'd100; arm = 1'b1;
        tick();
        rd_en = 1'b0; arm = 1'b0;
        check("b2b_old2_data", 32'(rd_data), 32'({2'b00, ev2}));
        repeat (PRE_TRIG) tick();
        trigger_and_finish(7, ev3);
        check("b2b_wave3", 32'(wave_number), 3);
        read_record(ev3);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
